// File: rtl/bcd_pkg.sv
// bcd_pkg: shared definitions for the BCD conversion paths (the keypad-side
// BCD-to-binary converter and the display-side binary-to-BCD converter).
//   state_t       - converter FSM states
//   BCD_MAX_DIGIT - largest legal BCD digit value
//   MAX_MAG       - largest magnitude representable in the 16-bit binary domain
//   BCD_MINUS     - display code for a minus sign
//   BCD_BLANK     - display code for a blanked digit
//   ACC_W         - accumulator width; 99999 fits, so it never wraps
package bcd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CHECK,
    ST_ACCUM,
    ST_DONE
  } state_t;

  localparam logic [3:0]  BCD_MAX_DIGIT = 4'd9;
  localparam int unsigned MAX_MAG       = 65535;
  localparam logic [3:0]  BCD_MINUS     = 4'hA;
  localparam logic [3:0]  BCD_BLANK     = 4'hF;
  localparam int unsigned ACC_W         = 17;

  // True for the six non-decimal codes A..F.
  function automatic logic bcd_digit_bad(input logic [3:0] digit);
    return digit > BCD_MAX_DIGIT;
  endfunction

endpackage

// File: rtl/bcd_mac10.sv
// bcd_mac10: combinational multiply-by-10 accumulate step, mac = acc*10 + digit.
//   acc   - running accumulator (ACC_W bits)
//   digit - next BCD digit, most-significant first
//   mac   - acc*10 + digit, truncated to ACC_W bits
// The truncation is unreachable in use: the largest 5-digit value, 99999,
// is below 2^17, and every intermediate accumulator is smaller still.
module bcd_mac10
  import bcd_pkg::*;
(
  input  logic [ACC_W-1:0] acc,
  input  logic [3:0]       digit,
  output logic [ACC_W-1:0] mac
);

  logic [ACC_W-1:0] acc_x8;
  logic [ACC_W-1:0] acc_x2;

  // acc*10 as two shifts and an add; no multiplier needed.
  assign acc_x8 = acc << 3;
  assign acc_x2 = acc << 1;
  assign mac    = acc_x8 + acc_x2 + {{(ACC_W-4){1'b0}}, digit};

endmodule

// File: rtl/bcd_to_bin16_seq.sv
// bcd_to_bin16_seq: sequential 5-digit BCD (plus sign) to 16-bit binary
// converter for operand entry. One digit is folded in per cycle, MSD first,
// behind a start/busy/done handshake.
//   clk      - clock, all state on rising edge
//   rst_n    - asynchronous active-low reset
//   start    - request a conversion; only honoured while idle
//   d0..d4   - BCD digits, d0 = ones ... d4 = ten-thousands
//   sign_neg - 1 = negative operand
//   busy     - high whenever a conversion is in progress (state != IDLE)
//   done     - one-cycle pulse; results valid in this cycle and held afterwards
//   bin_out  - magnitude (saturates to 16'hFFFF on overflow)
//   sign_out - result sign, forced 0 for a zero magnitude
//   val_out  - 17-bit two's complement of {sign_out, bin_out}
//   invalid  - a captured digit was above 9
//   overflow - decimal value exceeded MAX_MAG
module bcd_to_bin16_seq #(
  parameter int unsigned NDIG    = 5,
  parameter int unsigned MAX_MAG = bcd_pkg::MAX_MAG
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [3:0]  d0,
  input  logic [3:0]  d1,
  input  logic [3:0]  d2,
  input  logic [3:0]  d3,
  input  logic [3:0]  d4,
  input  logic        sign_neg,
  output logic        busy,
  output logic        done,
  output logic [15:0] bin_out,
  output logic        sign_out,
  output logic [16:0] val_out,
  output logic        invalid,
  output logic        overflow
);

  import bcd_pkg::*;

  localparam int unsigned      IDX_W     = $clog2(NDIG);
  localparam logic [ACC_W-1:0] MAX_MAG_W = ACC_W'(MAX_MAG);
  localparam logic [IDX_W-1:0] IDX_MSD   = IDX_W'(NDIG - 1);

  // Captured operand and iteration state
  state_t                   state;
  state_t                   state_nxt;
  logic [NDIG-1:0][3:0]     dig_q;
  logic                     sign_q;
  logic [ACC_W-1:0]         acc_q;
  logic [ACC_W-1:0]         acc_nxt;
  logic [IDX_W-1:0]         idx_q;
  logic [IDX_W-1:0]         idx_nxt;

  // Control strobes from the next-state logic
  logic                     capture;
  logic                     load;
  logic                     any_bad;

  // Accumulate step and formatted result
  logic [ACC_W-1:0]         mac;
  logic [15:0]              res_bin;
  logic                     res_sign;
  logic [16:0]              res_val;
  logic                     res_invalid;
  logic                     res_overflow;

  bcd_mac10 u_mac10 (
    .acc   (acc_q),
    .digit (dig_q[idx_q]),
    .mac   (mac)
  );

  always_comb begin
    any_bad = 1'b0;
    for (int unsigned i = 0; i < NDIG; i++) begin
      if (bcd_digit_bad(dig_q[i])) any_bad = 1'b1;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    acc_nxt   = acc_q;
    idx_nxt   = idx_q;
    capture   = 1'b0;
    load      = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (start) begin
          capture   = 1'b1;
          acc_nxt   = '0;
          idx_nxt   = IDX_MSD;
          state_nxt = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (any_bad) begin
          load      = 1'b1;
          state_nxt = ST_DONE;
        end else begin
          state_nxt = ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        acc_nxt = mac;
        if (idx_q == '0) begin
          load      = 1'b1;
          state_nxt = ST_DONE;
        end else begin
          idx_nxt = idx_q - 1'b1;
        end
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Result formatting. The output registers are written on the edge that
  // enters DONE so that results are already valid in the cycle done is high.
  // A load from CHECK is always the invalid case; a load from ACCUM uses the
  // final accumulate value straight from the MAC.
  always_comb begin
    res_bin      = '0;
    res_sign     = 1'b0;
    res_invalid  = 1'b0;
    res_overflow = 1'b0;
    if (state == ST_CHECK) begin
      res_invalid = 1'b1;
    end else if (mac > MAX_MAG_W) begin
      res_bin      = '1;
      res_sign     = sign_q;
      res_overflow = 1'b1;
    end else begin
      res_bin  = mac[15:0];
      res_sign = sign_q & (mac != '0);
    end
    res_val = res_sign ? (~{1'b0, res_bin} + 17'd1) : {1'b0, res_bin};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      dig_q  <= '0;
      sign_q <= 1'b0;
      acc_q  <= '0;
      idx_q  <= '0;
    end else begin
      state <= state_nxt;
      acc_q <= acc_nxt;
      idx_q <= idx_nxt;
      if (capture) begin
        dig_q  <= {d4, d3, d2, d1, d0};
        sign_q <= sign_neg;
      end
    end
  end

  // Result registers hold their value until the next conversion completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_out  <= '0;
      sign_out <= 1'b0;
      val_out  <= '0;
      invalid  <= 1'b0;
      overflow <= 1'b0;
    end else if (load) begin
      bin_out  <= res_bin;
      sign_out <= res_sign;
      val_out  <= res_val;
      invalid  <= res_invalid;
      overflow <= res_overflow;
    end
  end

  assign busy = (state != ST_IDLE);
  assign done = (state == ST_DONE);

endmodule

// File: tb/tb_bcd_to_bin16_seq.sv
module tb_bcd_to_bin16_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [3:0]  d0, d1, d2, d3, d4;
  logic        sign_neg;
  logic        busy;
  logic        done;
  logic [15:0] bin_out;
  logic        sign_out;
  logic [16:0] val_out;
  logic        invalid;
  logic        overflow;

  int n_chk  = 0;
  int n_fail = 0;

  bcd_to_bin16_seq #(
    .NDIG    (5),
    .MAX_MAG (65535)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .d0       (d0),
    .d1       (d1),
    .d2       (d2),
    .d3       (d3),
    .d4       (d4),
    .sign_neg (sign_neg),
    .busy     (busy),
    .done     (done),
    .bin_out  (bin_out),
    .sign_out (sign_out),
    .val_out  (val_out),
    .invalid  (invalid),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [19:0] dg;     // {d4,d3,d2,d1,d0}
    logic        sg;
    logic [15:0] eb;
    logic        es;
    logic [16:0] ev;
    logic        ei;
    logic        eo;
    int          elat;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference: plain decimal arithmetic on the digit values.
  task automatic model(input logic [19:0] dg, input logic sg,
                       output logic [15:0] b, output logic s, output logic [16:0] v,
                       output logic inv, output logic ovf, output int lat);
    int unsigned val;
    int signed   sv;
    logic [31:0] sv_bits;
    val = 0;
    inv = 1'b0;
    for (int i = 4; i >= 0; i--) begin
      if (dg[i*4 +: 4] > 4'd9) inv = 1'b1;
      val = val * 10 + int'(dg[i*4 +: 4]);
    end
    ovf = 1'b0;
    if (inv) begin
      b = 16'd0; s = 1'b0; lat = 2;
    end else if (val > 65535) begin
      b = 16'hFFFF; s = sg; ovf = 1'b1; lat = 7;
    end else begin
      b = val[15:0]; s = sg && (val != 0); lat = 7;
    end
    sv      = s ? -int'(b) : int'(b);
    sv_bits = sv;
    v       = sv_bits[16:0];
  endtask

  // Call at a negedge. Returns at the negedge inside the done cycle, or -1.
  task automatic do_conv(input string nm, input logic [19:0] dg, input logic sg, output int lat);
    {d4, d3, d2, d1, d0} = dg;
    sign_neg = sg;
    start    = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    lat = -1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      chk({nm, "_busy"}, busy, 1);
      if (done) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic run_check(input string nm, input logic [19:0] dg, input logic sg,
                           input logic [15:0] eb, input logic es, input logic [16:0] ev,
                           input logic ei, input logic eo, input int elat);
    int lat;
    do_conv(nm, dg, sg, lat);
    chk({nm, "_latency"}, lat, elat);
    chk({nm, "_bin"}, bin_out, eb);
    chk({nm, "_sign"}, sign_out, es);
    chk({nm, "_val"}, val_out, ev);
    chk({nm, "_invalid"}, invalid, ei);
    chk({nm, "_overflow"}, overflow, eo);
    @(negedge clk);
    chk({nm, "_done_pulse"}, done, 0);
    chk({nm, "_idle"}, busy, 0);
    chk({nm, "_hold_val"}, val_out, ev);
  endtask

  vec_t vecs[9];

  initial begin
    logic [15:0] mb;
    logic        ms, mi, mo;
    logic [16:0] mv;
    int          ml;
    int          n_done;
    logic [19:0] dg;

    vecs[0] = '{20'h12345, 1'b0, 16'h3039, 1'b0, 17'h03039, 1'b0, 1'b0, 7};
    vecs[1] = '{20'h65535, 1'b1, 16'hFFFF, 1'b1, 17'h10001, 1'b0, 1'b0, 7};
    vecs[2] = '{20'h65536, 1'b0, 16'hFFFF, 1'b0, 17'h0FFFF, 1'b0, 1'b1, 7};
    vecs[3] = '{20'h00A00, 1'b0, 16'h0000, 1'b0, 17'h00000, 1'b1, 1'b0, 2};
    vecs[4] = '{20'h00000, 1'b1, 16'h0000, 1'b0, 17'h00000, 1'b0, 1'b0, 7};
    vecs[5] = '{20'h99999, 1'b1, 16'hFFFF, 1'b1, 17'h10001, 1'b0, 1'b1, 7};
    vecs[6] = '{20'h00001, 1'b1, 16'h0001, 1'b1, 17'h1FFFF, 1'b0, 1'b0, 7};
    vecs[7] = '{20'hF0000, 1'b1, 16'h0000, 1'b0, 17'h00000, 1'b1, 1'b0, 2};
    vecs[8] = '{20'h65536, 1'b1, 16'hFFFF, 1'b1, 17'h10001, 1'b0, 1'b1, 7};

    rst_n = 1'b0; start = 1'b0; sign_neg = 1'b0;
    {d4, d3, d2, d1, d0} = 20'h0;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_bin", bin_out, 0);
    chk("rst_sign", sign_out, 0);
    chk("rst_val", val_out, 0);
    chk("rst_invalid", invalid, 0);
    chk("rst_overflow", overflow, 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 9; i++) begin
      run_check($sformatf("vec%0d", i), vecs[i].dg, vecs[i].sg, vecs[i].eb, vecs[i].es,
                vecs[i].ev, vecs[i].ei, vecs[i].eo, vecs[i].elat);
    end

    // start held high; digits change after capture
    {d4, d3, d2, d1, d0} = 20'h00042;
    sign_neg = 1'b0;
    start    = 1'b1;
    @(posedge clk);
    #1 {d4, d3, d2, d1, d0} = 20'h00100;
    n_done = 0;
    for (int c = 1; c <= 24; c++) begin
      @(negedge clk);
      if (c == 8) chk("b2b_idle_gap", busy, 0);
      if (c == 9) begin
        chk("b2b_recapture", busy, 1);
        start = 1'b0;
      end
      if (done) begin
        if (n_done == 0) begin
          chk("b2b_first_lat", c, 7);
          chk("b2b_first_bin", bin_out, 16'd42);
        end else if (n_done == 1) begin
          chk("b2b_second_lat", c, 15);
          chk("b2b_second_bin", bin_out, 16'd100);
        end
        n_done++;
      end
    end
    chk("b2b_done_count", n_done, 2);

    // reset in the middle of a conversion
    run_check("pre_rst", 20'h12345, 1'b1, 16'h3039, 1'b1, 17'h1CFC7, 1'b0, 1'b0, 7);
    {d4, d3, d2, d1, d0} = 20'h10000;
    sign_neg = 1'b0;
    start    = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_bin", bin_out, 0);
    chk("midrst_sign", sign_out, 0);
    chk("midrst_val", val_out, 0);
    @(negedge clk);
    rst_n = 1'b1;
    n_done = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (done) n_done++;
    end
    chk("midrst_no_done", n_done, 0);
    chk("midrst_still_zero", bin_out, 0);
    run_check("post_rst", 20'h10000, 1'b0, 16'h2710, 1'b0, 17'h02710, 1'b0, 1'b0, 7);

    // randomized against the decimal reference
    for (int i = 0; i < 40; i++) begin
      dg = 20'h0;
      for (int k = 0; k < 5; k++) dg[k*4 +: 4] = 4'($urandom_range(0, 9));
      if ($urandom_range(0, 7) == 0) dg[$urandom_range(0, 4)*4 +: 4] = 4'($urandom_range(10, 15));
      ms = 1'($urandom_range(0, 1));
      model(dg, ms, mb, ms, mv, mi, mo, ml);
      run_check($sformatf("rnd%0d_%05h", i, dg), dg, ms, mb, ms, mv, mi, mo, ml);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/bcd_to_bin16_seq.md
# bcd_to_bin16_seq

Sequential BCD-to-binary converter: the inverse of the display path's binary-to-BCD stage. It takes a 5-digit BCD magnitude plus sign, for example operand entry from switches or a keypad, and produces a 16-bit binary magnitude, a sign bit and a 17-bit two's-complement value for the serial-parallel multiplier datapath. Conversion is an iterative multiply-by-10 accumulate, one digit per cycle, most-significant digit first, behind a start/busy/done handshake.

## Interface
Parameters:
- NDIG, 5, number of BCD digits converted; fixed at 5 for 16-bit range.
- MAX_MAG, 65535, largest legal magnitude; above this is overflow.

Ports:
- clk  input  1  single clock; all state on rising edge
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  request conversion; honoured only in IDLE
- d0..d4  input  4 each  BCD digits, d0 = ones … d4 = ten-thousands
- sign_neg  input  1  1 = negative operand
- busy  output  1  high whenever state ≠ IDLE
- done  output  1  one-cycle pulse; results valid this cycle and held afterwards
- bin_out  output  16  converted magnitude
- sign_out  output  1  result sign; forced 0 when magnitude is 0
- val_out  output  17  signed two's-complement of {sign_out, bin_out}
- invalid  output  1  some captured digit > 9
- overflow  output  1  decimal value > MAX_MAG

## Operation
- States: IDLE, CHECK, ACCUM, DONE.
- IDLE, start=1: capture d0..d4 and sign_neg into internal registers; clear acc (17 bit) and the digit index (idx = 4); go to CHECK.
- CHECK: if any captured digit > 9, set the pending invalid flag and go to DONE. Otherwise go to ACCUM.
- ACCUM: each cycle computes acc ← acc·10 + digit[idx], with acc·10 = (acc<<3)+(acc<<1). After idx = 0 is processed, go to DONE. 99999 < 2^17, so 17 bits never wrap.
- DONE: load the output registers and pulse done, then return to IDLE.
  - Invalid: bin_out=0, sign_out=0, val_out=0, invalid=1, overflow=0.
  - acc > MAX_MAG: bin_out=16'hFFFF (saturate), overflow=1, invalid=0, sign_out=sign_neg.
  - Otherwise: bin_out=acc[15:0], sign_out=sign_neg & (acc≠0).
  - In all cases val_out = sign_out ? -{1'b0,bin_out} : {1'b0,bin_out}.
- start while busy (CHECK/ACCUM/DONE) is ignored. It is not queued. Input digit changes after capture have no effect.
- Outputs keep their last DONE values until the next DONE, across idle periods and during a new conversion.

## Timing
- Reset (async assert, sync release): state=IDLE, busy=0, done=0, bin_out=0, sign_out=0, val_out=0, invalid=0, overflow=0, acc=0.
- Valid conversion: start sampled at edge N. CHECK runs in N+1, ACCUM in N+2…N+6, and DONE in N+7 (done=1, outputs updated at that edge). IDLE resumes at N+8, so back-to-back start is accepted at N+8.
- Invalid conversion: CHECK in N+1, done in N+2.
- busy=1 from N+1 through the done cycle inclusive. done and busy are both high in the DONE cycle.
- Reset asserted mid-conversion: immediate return to reset values. No done pulse is issued and previous results are lost.

## Structure
- Shared package (bcd_pkg), used with the display-side converter:
  - state enum
  - BCD_MAX_DIGIT = 9
  - MAX_MAG = 65535
  - BCD_MINUS = 4'hA and BCD_BLANK = 4'hF display codes
- One natural sub-module: bcd_mac10. It is combinational: 17-bit acc and a 4-bit digit in, acc·10+digit out, with 17-bit truncation documented as unreachable.

## Test plan
- d4..d0 = 1,2,3,4,5, sign_neg=0, start at N -> done at N+7, bin_out=16'h3039, val_out=17'h03039, flags 0, busy high N+1…N+7.
- 6,5,5,3,5, sign_neg=1 -> bin_out=16'hFFFF, sign_out=1, val_out=17'h10001, overflow=0. Then 6,5,5,3,6 -> overflow=1, bin_out=16'hFFFF.
- d2=4'hA (others 0) -> done at N+2, invalid=1, bin_out=0, val_out=0.
- 0,0,0,0,0, sign_neg=1 -> sign_out=0, val_out=0, done at N+7.
- 0,0,0,4,2: start held high N..N+8 while digits change after N -> first result 42 at N+7. The second conversion starts at N+8, with no capture during busy.
- Conversion 1,0,0,0,0, assert rst_n=0 at N+4 -> all outputs 0, no done. After release, a new start completes normally.
